tempsense_result_filter: RTL and testbench

//  Downstream stage of the temperature-sensor measurement FSM. Consumes each raw
//  N_VDAC-bit DAC-threshold code produced at the end of a sweep. Emits:
//   - a block-averaged code, one per 2**LOG2_AVG accepted samples
//   - running min/max since the last clear
//   - an over/under-temperature alarm with hysteresis

---
 rtl/tempsense_pkg.sv | 15 +
 rtl/tempsense_minmax.sv | 58 +++++
 rtl/tempsense_result_filter.sv | 117 +++++++++++
 tb/tb_tempsense_result_filter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tempsense_pkg.sv
// Shared definitions for the temperature-sensor datapath: result code width,
// code limits and the result-filter state encoding.
package tempsense_pkg;

  localparam int unsigned N_VDAC_DEF = 6;

  localparam logic [N_VDAC_DEF-1:0] VMAX = '1;
  localparam logic [N_VDAC_DEF-1:0] VMIN = '0;

  typedef enum logic {
    S_DISCARD = 1'b0,
    S_ACCUM   = 1'b1
  } filt_state_e;

endpackage

// File: rtl/tempsense_minmax.sv
// Running minimum/maximum of accepted result codes, with a clear strobe.
// A sample arriving together with a clear becomes the first sample after the clear.
module tempsense_minmax
  import tempsense_pkg::*;
#(
  parameter int unsigned N_VDAC = N_VDAC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid_i,
  input  logic [N_VDAC-1:0] sample_i,
  input  logic              clr_i,
  output logic [N_VDAC-1:0] min_o,
  output logic [N_VDAC-1:0] max_o,
  output logic              vld_o
);

  logic [N_VDAC-1:0] min_q, min_d;
  logic [N_VDAC-1:0] max_q, max_d;
  logic              vld_q, vld_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    vld_d = vld_q;
    if (sample_valid_i) begin
      vld_d = 1'b1;
      if (clr_i || !vld_q) begin
        min_d = sample_i;
        max_d = sample_i;
      end else begin
        if (sample_i < min_q) min_d = sample_i;
        if (sample_i > max_q) max_d = sample_i;
      end
    end else if (clr_i) begin
      min_d = '1;
      max_d = '0;
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
      vld_q <= 1'b0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      vld_q <= vld_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/tempsense_result_filter.sv
// Result filter behind the sensor sweep FSM: drops the first sweeps after reset,
// block-averages accepted codes, tracks min/max and raises a hysteretic alarm.
module tempsense_result_filter
  import tempsense_pkg::*;
#(
  parameter int unsigned N_VDAC    = N_VDAC_DEF,
  parameter int unsigned LOG2_AVG  = 2,
  parameter int unsigned N_DISCARD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_res_valid,
  input  logic [N_VDAC-1:0] i_res,
  input  logic              i_clr_minmax,
  input  logic [N_VDAC-1:0] i_thr_hi,
  input  logic [N_VDAC-1:0] i_thr_lo,
  output logic [N_VDAC-1:0] o_avg,
  output logic              o_avg_valid,
  output logic [N_VDAC-1:0] o_min,
  output logic [N_VDAC-1:0] o_max,
  output logic              o_minmax_vld,
  output logic              o_alarm
);

  localparam int unsigned ACC_W  = N_VDAC + LOG2_AVG;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned CNT_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned DISC_W = (N_DISCARD > 0) ? $clog2(N_DISCARD + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(N_DISCARD - 1);
  // Half an LSB of the output for round-half-up; zero in pass-through mode.
  localparam logic [SUM_W-1:0]  HALF      = SUM_W'((1 << LOG2_AVG) >> 1);
  localparam logic [SUM_W-1:0]  AVG_MAX   = SUM_W'((1 << N_VDAC) - 1);
  localparam filt_state_e       RST_STATE = (N_DISCARD == 0) ? S_ACCUM : S_DISCARD;

  filt_state_e       state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DISC_W-1:0] disc_q;
  logic [N_VDAC-1:0] avg_q;
  logic              avg_valid_q;
  logic              alarm_q;

  logic              accept;
  logic              blk_done;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  rounded;
  logic [N_VDAC-1:0] avg_new;

  always_comb begin
    accept   = i_res_valid && (state_q == S_ACCUM);
    blk_done = accept && (cnt_q == CNT_LAST);
    sum      = SUM_W'(acc_q) + SUM_W'(i_res);
    rounded  = (sum + HALF) >> LOG2_AVG;
    avg_new  = (rounded > AVG_MAX) ? '1 : rounded[N_VDAC-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_STATE;
      acc_q       <= '0;
      cnt_q       <= '0;
      disc_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      avg_valid_q <= blk_done;
      unique case (state_q)
        S_DISCARD: begin
          if (i_res_valid) begin
            disc_q <= disc_q + 1'b1;
            if (disc_q == DISC_LAST) state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (i_res_valid) begin
            if (blk_done) begin
              // The final sample goes straight into the average; the next block starts empty.
              acc_q <= '0;
              cnt_q <= '0;
              avg_q <= avg_new;
              if (avg_new >= i_thr_hi) begin
                alarm_q <= 1'b1;
              end else if (avg_new <= i_thr_lo) begin
                alarm_q <= 1'b0;
              end
            end else begin
              acc_q <= acc_q + ACC_W'(i_res);
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= RST_STATE;
      endcase
    end
  end

  tempsense_minmax #(
    .N_VDAC(N_VDAC)
  ) u_minmax (
    .clk           (clk),
    .reset         (reset),
    .sample_valid_i(accept),
    .sample_i      (i_res),
    .clr_i         (i_clr_minmax),
    .min_o         (o_min),
    .max_o         (o_max),
    .vld_o         (o_minmax_vld)
  );

  assign o_avg       = avg_q;
  assign o_avg_valid = avg_valid_q;
  assign o_alarm     = alarm_q;

endmodule

// File: tb/tb_tempsense_result_filter.sv
// Directed bench for tempsense_result_filter: a 4-sample averaging instance and a
// pass-through instance share stimulus and are checked every cycle against a sample-level model.
module tb_tempsense_result_filter;

  typedef struct {
    int disc;
    int bsum;
    int bn;
    int avg;
    bit avg_valid;
    int mn;
    int mx;
    bit have;
    bit alarm;
  } mdl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       res_valid = 1'b0;
  logic [5:0] res = '0;
  logic       clr_mm = 1'b0;
  logic [5:0] thr_hi = 6'd63;
  logic [5:0] thr_lo = 6'd62;

  logic [5:0] a_avg, a_min, a_max, b_avg, b_min, b_max;
  logic       a_avg_valid, a_mm_vld, a_alarm, b_avg_valid, b_mm_vld, b_alarm;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  tempsense_result_filter #(.N_VDAC(6), .LOG2_AVG(2), .N_DISCARD(1)) dut_a (
    .clk(clk), .reset(reset), .i_res_valid(res_valid), .i_res(res),
    .i_clr_minmax(clr_mm), .i_thr_hi(thr_hi), .i_thr_lo(thr_lo),
    .o_avg(a_avg), .o_avg_valid(a_avg_valid), .o_min(a_min), .o_max(a_max),
    .o_minmax_vld(a_mm_vld), .o_alarm(a_alarm)
  );

  tempsense_result_filter #(.N_VDAC(6), .LOG2_AVG(0), .N_DISCARD(1)) dut_b (
    .clk(clk), .reset(reset), .i_res_valid(res_valid), .i_res(res),
    .i_clr_minmax(clr_mm), .i_thr_hi(thr_hi), .i_thr_lo(thr_lo),
    .o_avg(b_avg), .o_avg_valid(b_avg_valid), .o_min(b_min), .o_max(b_max),
    .o_minmax_vld(b_mm_vld), .o_alarm(b_alarm)
  );

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Sample-level model: a block is a list of 2**l2 accepted samples, averaged with round-half-up.
  task automatic model_step(input int l2, input int nd, inout mdl_t m);
    int n;
    int a;
    bit accepted;
    m.avg_valid = 1'b0;
    if (reset) begin
      m.disc = 0; m.bsum = 0; m.bn = 0; m.avg = 0;
      m.mn = 63; m.mx = 0; m.have = 1'b0; m.alarm = 1'b0;
      return;
    end
    accepted = res_valid && (m.disc >= nd);
    if (res_valid && !accepted) m.disc++;
    if (accepted) begin
      n = 1 << l2;
      m.bsum += int'(res);
      m.bn++;
      if (m.bn == n) begin
        a = (m.bsum + n / 2) / n;
        if (a > 63) a = 63;
        m.avg = a;
        m.avg_valid = 1'b1;
        if (a >= int'(thr_hi)) m.alarm = 1'b1;
        else if (a <= int'(thr_lo)) m.alarm = 1'b0;
        m.bsum = 0;
        m.bn = 0;
      end
      if (clr_mm || !m.have) begin
        m.mn = int'(res);
        m.mx = int'(res);
      end else begin
        if (int'(res) < m.mn) m.mn = int'(res);
        if (int'(res) > m.mx) m.mx = int'(res);
      end
      m.have = 1'b1;
    end else if (clr_mm) begin
      m.mn = 63; m.mx = 0; m.have = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    model_step(2, 1, ma);
    model_step(0, 1, mb);
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("A.avg", a_avg, ma.avg);
      chk("A.avg_valid", a_avg_valid, ma.avg_valid);
      chk("A.min", a_min, ma.mn);
      chk("A.max", a_max, ma.mx);
      chk("A.minmax_vld", a_mm_vld, ma.have);
      chk("A.alarm", a_alarm, ma.alarm);
      chk("B.avg", b_avg, mb.avg);
      chk("B.avg_valid", b_avg_valid, mb.avg_valid);
      chk("B.min", b_min, mb.mn);
      chk("B.max", b_max, mb.mx);
      chk("B.minmax_vld", b_mm_vld, mb.have);
      chk("B.alarm", b_alarm, mb.alarm);
    end
  end

  task automatic cyc(input bit v, input int val, input bit clr);
    @(negedge clk);
    res_valid = v;
    res = 6'(val);
    clr_mm = clr;
  endtask

  task automatic chk_reset_state();
    chk("rst.avg", a_avg, 0);
    chk("rst.avg_valid", a_avg_valid, 0);
    chk("rst.min", a_min, 63);
    chk("rst.max", a_max, 0);
    chk("rst.minmax_vld", a_mm_vld, 0);
    chk("rst.alarm", a_alarm, 0);
  endtask

  initial begin
    int c1[5] = '{40, 10, 12, 13, 14};
    int c3_avg[5] = '{25, 31, 25, 20, 25};
    int c3_alarm[5] = '{0, 1, 1, 0, 0};

    @(negedge clk);
    checking = 1'b1;
    chk_reset_state();
    reset = 1'b0;

    // Case 1: first strobe discarded, (49+2)>>2 = 12
    foreach (c1[i]) cyc(1'b1, c1[i], 1'b0);
    cyc(1'b0, 0, 1'b0);
    chk("c1.avg", a_avg, 12);
    chk("c1.avg_valid", a_avg_valid, 1);
    chk("c1.min", a_min, 10);
    chk("c1.max", a_max, 14);
    cyc(1'b0, 0, 1'b0);
    chk("c1.avg_valid_pulse", a_avg_valid, 0);

    // Case 2: full-scale block must not wrap; then (5+2)>>2 = 1
    repeat (4) cyc(1'b1, 63, 1'b0);
    cyc(1'b0, 0, 1'b0);
    chk("c2.avg_full", a_avg, 63);
    chk("c2.alarm_set", a_alarm, 1);
    cyc(1'b1, 1, 1'b0);
    cyc(1'b1, 1, 1'b0);
    cyc(1'b1, 1, 1'b0);
    cyc(1'b1, 2, 1'b0);
    cyc(1'b0, 0, 1'b0);
    chk("c2.avg_round", a_avg, 1);
    chk("c2.alarm_clr", a_alarm, 0);

    // Case 3: hysteresis with set 30 / clear 20
    thr_hi = 6'd30;
    thr_lo = 6'd20;
    for (int i = 0; i < 5; i++) begin
      repeat (4) cyc(1'b1, c3_avg[i], 1'b0);
      cyc(1'b0, 0, 1'b0);
      chk("c3.avg", a_avg, c3_avg[i]);
      chk("c3.alarm", a_alarm, c3_alarm[i]);
    end

    // Case 4: clear coinciding with a sample, then clear alone
    cyc(1'b1, 7, 1'b1);
    cyc(1'b0, 0, 1'b0);
    chk("c4.min", a_min, 7);
    chk("c4.max", a_max, 7);
    chk("c4.vld", a_mm_vld, 1);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b0);
    chk("c4.clr_min", a_min, 63);
    chk("c4.clr_max", a_max, 0);
    chk("c4.clr_vld", a_mm_vld, 0);

    // Case 5: reset with a partial block pending
    cyc(1'b1, 9, 1'b0);
    cyc(1'b1, 9, 1'b0);
    cyc(1'b0, 0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 0, 1'b0);
    chk_reset_state();
    reset = 1'b0;
    cyc(1'b1, 50, 1'b0);
    repeat (3) cyc(1'b1, 8, 1'b0);
    cyc(1'b0, 0, 1'b0);
    chk("c5.no_early_valid", a_avg_valid, 0);
    chk("c5.avg_held", a_avg, 0);
    cyc(1'b1, 8, 1'b0);
    cyc(1'b0, 0, 1'b0);
    chk("c5.avg", a_avg, 8);
    chk("c5.avg_valid", a_avg_valid, 1);

    // Case 6: back-to-back strobes through the pass-through instance
    cyc(1'b1, 3, 1'b0);
    cyc(1'b1, 4, 1'b0);
    chk("c6.avg0", b_avg, 3);
    chk("c6.vld0", b_avg_valid, 1);
    cyc(1'b1, 5, 1'b0);
    chk("c6.avg1", b_avg, 4);
    chk("c6.vld1", b_avg_valid, 1);
    cyc(1'b0, 0, 1'b0);
    chk("c6.avg2", b_avg, 5);
    chk("c6.vld2", b_avg_valid, 1);
    cyc(1'b0, 0, 1'b0);
    chk("c6.vld_end", b_avg_valid, 0);

    // Inverted thresholds: set wins
    thr_hi = 6'd10;
    thr_lo = 6'd40;
    cyc(1'b1, 25, 1'b0);
    cyc(1'b0, 0, 1'b0);
    chk("inv_thr.alarm", b_alarm, 1);
    cyc(1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
